dma_wr_arbiter: RTL and testbench

- Parametrised N-channel write arbiter. Merges NCH Avalon-MM style DMA write masters onto one SDRAM write port.
- Successor to the fixed 3-channel time-slot mux.
- Work-conserving round-robin: idle channels consume no slots.
- Optional burst hold (MAX_BURST) keeps the grant on a channel for SDRAM page locality.
- Registered output stage with correct waitrequest back-pressure: one beat per cycle sustained.

---
 rtl/dma_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_dma_wr_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wr_arbiter.sv
// N-channel DMA write arbiter: work-conserving round-robin with burst hold, one registered SDRAM beat.
// Optional `DMA_WR_ARBITER_PRIO0_EN gives channel 0 strict priority over the round-robin channels.
module dma_wr_arbiter #(
  parameter int NCH       = 3,
  parameter int DW        = 128,
  parameter int AW        = 28,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*DW-1:0] DMA_DATA,
  input  logic [NCH*AW-1:0] DMA_ADR,
  input  logic [NCH-1:0]    DMA_WR,
  output logic [NCH-1:0]    DMA_WAITREQ,
  output logic [DW-1:0]     SDRAM_WRITEDATA,
  output logic [AW-1:0]     SDRAM_ADDRESS,
  output logic              SDRAM_WRITE,
  input  logic              SDRAM_WAITREQUEST
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  logic              sdram_write_r;
  logic [DW-1:0]     sdram_writedata_r;
  logic [AW-1:0]     sdram_address_r;
  logic [PW-1:0]     last_r;
  logic [PW-1:0]     cur_r;
  logic [CW-1:0]     count_r;
  logic              lock_r;

  logic              free_s;
  logic              hold_s;
  logic [PW:0]       rr_s;
  logic              gnt_valid_s;
  logic [PW-1:0]     gnt_idx_s;
  logic [NCH-1:0]    dma_waitreq_s;

  // First requester after 'last', wrapping modulo NCH; MSB flags that one was found.
  function automatic logic [PW:0] rr_pick(input logic [PW-1:0] last, input logic [NCH-1:0] req);
    logic          found;
    logic          hit;
    logic [PW-1:0] idx;
    logic [PW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand  = PW'((int'(last) + k) % NCH);
      hit   = req[cand] && !found;
      idx   = hit ? cand : idx;
      found = found | hit;
    end
    return {found, idx};
  endfunction

  assign free_s = !sdram_write_r || !SDRAM_WAITREQUEST;
  assign hold_s = lock_r && DMA_WR[cur_r] && (count_r < CW'(MAX_BURST));
  assign rr_s   = rr_pick(last_r, DMA_WR);

  // Grant selection; nothing is granted while in reset or while the output beat is stalled.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    if (RST && free_s) begin
`ifdef DMA_WR_ARBITER_PRIO0_EN
      if (DMA_WR[0]) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = '0;
      end else if (hold_s) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = cur_r;
      end else begin
        gnt_valid_s = rr_s[PW];
        gnt_idx_s   = rr_s[PW-1:0];
      end
`else
      if (hold_s) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = cur_r;
      end else begin
        gnt_valid_s = rr_s[PW];
        gnt_idx_s   = rr_s[PW-1:0];
      end
`endif
    end else begin
      gnt_valid_s = 1'b0;
      gnt_idx_s   = '0;
    end
  end

  // Only the granted master sees waitrequest low, in the very cycle its beat is captured.
  always_comb begin
    dma_waitreq_s = '1;
    if (gnt_valid_s) begin
      dma_waitreq_s[gnt_idx_s] = 1'b0;
    end else begin
      dma_waitreq_s = '1;
    end
  end

  // Output beat register and round-robin / burst bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sdram_write_r     <= 1'b0;
      sdram_writedata_r <= '0;
      sdram_address_r   <= '0;
      last_r            <= PW'(NCH - 1);
      cur_r             <= '0;
      count_r           <= '0;
      lock_r            <= 1'b0;
    end else begin
      if (free_s) begin
        sdram_write_r <= gnt_valid_s;
        if (gnt_valid_s) begin
          sdram_writedata_r <= DMA_DATA[gnt_idx_s*DW +: DW];
          sdram_address_r   <= DMA_ADR[gnt_idx_s*AW +: AW];
        end
      end
      if (gnt_valid_s) begin
        last_r <= gnt_idx_s;
        lock_r <= 1'b1;
        // A re-grant after a completed burst (sole requester) starts a fresh burst count.
        if (lock_r && (gnt_idx_s == cur_r) && (count_r < CW'(MAX_BURST))) begin
          count_r <= count_r + CW'(1);
        end else begin
          cur_r   <= gnt_idx_s;
          count_r <= CW'(1);
        end
      end else if (lock_r && !DMA_WR[cur_r]) begin
        lock_r <= 1'b0;
      end
    end
  end

  assign DMA_WAITREQ     = dma_waitreq_s;
  assign SDRAM_WRITE     = sdram_write_r;
  assign SDRAM_WRITEDATA = sdram_writedata_r;
  assign SDRAM_ADDRESS   = sdram_address_r;

endmodule

// File: tb/tb_dma_wr_arbiter.sv
// Directed scoreboard bench for dma_wr_arbiter: three instances (MAX_BURST 1/4/2) share stimulus,
// the masters follow the instance under test, and tagged addresses identify every beat.
module tb_dma_wr_arbiter;

  localparam int NCH = 3;
  localparam int DW  = 128;
  localparam int AW  = 28;

  logic              CLK;
  logic              RST;
  logic [NCH*DW-1:0] dma_data;
  logic [NCH*AW-1:0] dma_adr;
  logic [NCH-1:0]    dma_wr;
  logic              sdram_waitreq;

  logic [NCH-1:0] wq1, wq4, wq2, wq_sel;
  logic [DW-1:0]  wd1, wd4, wd2, wd_sel;
  logic [AW-1:0]  ad1, ad4, ad2, ad_sel;
  logic           w1, w4, w2, w_sel;

  dma_wr_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .MAX_BURST(1)) u_mb1 (
    .CLK(CLK), .RST(RST), .DMA_DATA(dma_data), .DMA_ADR(dma_adr), .DMA_WR(dma_wr),
    .DMA_WAITREQ(wq1), .SDRAM_WRITEDATA(wd1), .SDRAM_ADDRESS(ad1), .SDRAM_WRITE(w1),
    .SDRAM_WAITREQUEST(sdram_waitreq));

  dma_wr_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .MAX_BURST(4)) u_mb4 (
    .CLK(CLK), .RST(RST), .DMA_DATA(dma_data), .DMA_ADR(dma_adr), .DMA_WR(dma_wr),
    .DMA_WAITREQ(wq4), .SDRAM_WRITEDATA(wd4), .SDRAM_ADDRESS(ad4), .SDRAM_WRITE(w4),
    .SDRAM_WAITREQUEST(sdram_waitreq));

  dma_wr_arbiter #(.NCH(NCH), .DW(DW), .AW(AW), .MAX_BURST(2)) u_mb2 (
    .CLK(CLK), .RST(RST), .DMA_DATA(dma_data), .DMA_ADR(dma_adr), .DMA_WR(dma_wr),
    .DMA_WAITREQ(wq2), .SDRAM_WRITEDATA(wd2), .SDRAM_ADDRESS(ad2), .SDRAM_WRITE(w2),
    .SDRAM_WAITREQUEST(sdram_waitreq));

  int sel;
  int vectors;
  int miscompares;
  int seq     [NCH];
  int exp_seq [NCH];
  int exp_q   [$];
  logic [NCH-1:0] wr_pat;
  logic           expect_busy;
  logic           stalled_prev;
  logic [AW-1:0]  prev_adr;
  logic [DW-1:0]  prev_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instance currently under test.
  always_comb begin
    case (sel)
      4:       begin wq_sel = wq4; wd_sel = wd4; ad_sel = ad4; w_sel = w4; end
      2:       begin wq_sel = wq2; wd_sel = wd2; ad_sel = ad2; w_sel = w2; end
      default: begin wq_sel = wq1; wd_sel = wd1; ad_sel = ad1; w_sel = w1; end
    endcase
  end

  function automatic logic [AW-1:0] mk_adr(input int ch, input int s);
    return AW'(32'h0500_0000 | (ch << 16) | (s & 32'h0000_FFFF));
  endfunction

  function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a) ^ 32'h3C3C_0000;
    return {w, ~w, w ^ 32'h0000_5A5A, w};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      dma_adr[i*AW +: AW]  = mk_adr(i, seq[i]);
      dma_data[i*DW +: DW] = mk_data(mk_adr(i, seq[i]));
    end
    dma_wr = wr_pat;
  endtask

  task automatic push(input int ch, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ch);
  endtask

  // One clock: check the output beat at the negedge, then advance masters whose beat was taken.
  task automatic cycle();
    logic [NCH-1:0] taken;
    int             ech;
    logic [AW-1:0]  ea;
    @(negedge CLK);
    taken = dma_wr & ~wq_sel;
    if (w_sel && sdram_waitreq) begin
      chk("stall_waitreq", DW'(wq_sel), DW'(3'b111));
      if (stalled_prev) begin
        chk("stall_hold_adr", DW'(ad_sel), DW'(prev_adr));
        chk("stall_hold_data", wd_sel, prev_data);
      end
      stalled_prev = 1'b1;
      prev_adr     = ad_sel;
      prev_data    = wd_sel;
    end else if (w_sel) begin
      stalled_prev = 1'b0;
      if (exp_q.size() == 0) begin
        ea = '1;
      end else begin
        ech = exp_q.pop_front();
        ea  = mk_adr(ech, exp_seq[ech]);
        exp_seq[ech]++;
      end
      chk("beat_adr", DW'(ad_sel), DW'(ea));
      chk("beat_data", wd_sel, mk_data(ea));
    end else begin
      stalled_prev = 1'b0;
    end
    if (expect_busy) chk("throughput", DW'(w_sel), DW'(1'b1));
    @(posedge CLK);
    #1;
    for (int i = 0; i < NCH; i++) if (taken[i]) seq[i]++;
    drive();
  endtask

  task automatic drain();
    wr_pat      = '0;
    expect_busy = 1'b0;
    drive();
    for (int i = 0; i < 16; i++) begin
      if (!w_sel) break;
      cycle();
    end
    chk("drain_idle", DW'(w_sel), DW'(1'b0));
    chk("drain_queue_empty", DW'(exp_q.size()), DW'(0));
  endtask

  task automatic do_reset(input logic [NCH-1:0] pat);
    RST    = 1'b0;
    wr_pat = pat;
    drive();
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("reset_waitreq", DW'(wq_sel), DW'(3'b111));
    end
    RST          = 1'b1;
    expect_busy  = 1'b0;
    stalled_prev = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    sel           = 1;
    RST           = 1'b0;
    sdram_waitreq = 1'b0;
    expect_busy   = 1'b0;
    stalled_prev  = 1'b0;
    prev_adr      = '0;
    prev_data     = '0;
    for (int i = 0; i < NCH; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    wr_pat = 3'b111;
    drive();
    @(posedge CLK);
    #1;

    // Reset held 3 cycles with every channel requesting.
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("reset_waitreq", DW'(wq_sel), DW'(3'b111));
      chk("reset_write", DW'(w_sel), DW'(1'b0));
      chk("reset_adr", DW'(ad_sel), DW'(0));
      chk("reset_data", wd_sel, DW'(0));
    end
    RST = 1'b1;
    #1;
    chk("first_grant_ch0", DW'(wq_sel), DW'(3'b110));

    // Pure round-robin, all channels requesting.
    for (int r = 0; r < 3; r++) begin push(0, 1); push(1, 1); push(2, 1); end
    for (int i = 0; i < 9; i++) begin cycle(); expect_busy = 1'b1; end
    drain();

    // Burst hold of 4 between ch1 and ch2.
    sel = 4;
    do_reset(3'b110);
    push(1, 4); push(2, 4); push(1, 4);
    for (int i = 0; i < 12; i++) begin cycle(); expect_busy = 1'b1; end
    drain();

    // ch1 drops WR after two beats; ch2 follows with no bubble.
    do_reset(3'b110);
    push(1, 2); push(2, 3);
    cycle();
    expect_busy = 1'b1;
    cycle();
    wr_pat = 3'b100;
    drive();
    for (int i = 0; i < 3; i++) cycle();
    drain();

    // Back-pressure for 5 cycles mid-stream.
    sel = 1;
    do_reset(3'b111);
    push(0, 1); push(1, 1); push(2, 1); push(0, 1);
    for (int i = 0; i < 4; i++) begin cycle(); expect_busy = 1'b1; end
    sdram_waitreq = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    sdram_waitreq = 1'b0;
    push(1, 1); push(2, 1); push(0, 1); push(1, 1);
    for (int i = 0; i < 4; i++) cycle();
    drain();

    // Single requester with MAX_BURST=2 keeps full throughput.
    sel = 2;
    do_reset(3'b100);
    push(2, 8);
    for (int i = 0; i < 8; i++) begin cycle(); expect_busy = 1'b1; end
    drain();

    // ch1 bursting when ch0 starts requesting.
    sel = 4;
    do_reset(3'b010);
    push(1, 1);
    cycle();
    wr_pat = 3'b011;
    drive();
    expect_busy = 1'b1;
`ifdef DMA_WR_ARBITER_PRIO0_EN
    push(0, 4);
`else
    push(1, 3); push(0, 1);
`endif
    for (int i = 0; i < 4; i++) cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
